// File: rtl/router_rr_arbiter.sv
// Round-robin arbiter sharing one router input among p_ninputs val/rdy requesters.
// Optional per-requester saturating grant counters: define ROUTER_RR_ARBITER_GRANT_COUNT_EN.
module router_rr_arbiter #(
  parameter int p_nbits   = 32,
  parameter int p_ninputs = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_ninputs-1:0]           recv_val,
  input  logic [p_ninputs*p_nbits-1:0]   recv_msg,
  output logic [p_ninputs-1:0]           recv_rdy,
  output logic                           send_val,
  output logic [p_nbits-1:0]             send_msg,
  output logic [$clog2(p_ninputs)-1:0]   send_src,
  input  logic                           send_rdy
`ifdef ROUTER_RR_ARBITER_GRANT_COUNT_EN
  ,
  output logic [p_ninputs*16-1:0]        grant_count
`endif
);
  localparam int PW = $clog2(p_ninputs);

  logic               r_full;
  logic [p_nbits-1:0] r_msg;
  logic [PW-1:0]      r_src;
  logic [PW-1:0]      r_ptr;

  logic               w_can_accept;
  logic               w_any;
  logic [PW-1:0]      w_win_idx;
  logic [PW-1:0]      w_ptr_nxt;
  logic               w_xfer;

  // Held low during reset so no requester sees a handshake while state is clearing.
  assign w_can_accept = !reset && (!r_full || send_rdy);

  always_comb begin
    int idx;
    idx       = 0;
    w_any     = 1'b0;
    w_win_idx = '0;
    for (int k = 0; k < p_ninputs; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= p_ninputs) idx = idx - p_ninputs;
      if (!w_any && recv_val[idx]) begin
        w_any     = 1'b1;
        w_win_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    recv_rdy = '0;
    if (w_any && w_can_accept) recv_rdy[w_win_idx] = 1'b1;
  end

  assign w_xfer    = w_any && w_can_accept;
  assign w_ptr_nxt = (int'(w_win_idx) == p_ninputs - 1) ? '0 : w_win_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_msg  <= '0;
      r_src  <= '0;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      r_full <= 1'b1;
      r_msg  <= recv_msg[int'(w_win_idx)*p_nbits +: p_nbits];
      r_src  <= w_win_idx;
      r_ptr  <= w_ptr_nxt;
    end else if (r_full && send_rdy) begin
      r_full <= 1'b0;
    end
  end

  assign send_val = r_full;
  assign send_msg = r_msg;
  assign send_src = r_src;

`ifdef ROUTER_RR_ARBITER_GRANT_COUNT_EN
  for (genvar g = 0; g < p_ninputs; g++) begin : g_cnt
    logic [15:0] r_cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 r_cnt <= '0;
      else if (recv_rdy[g] && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
    assign grant_count[g*16 +: 16] = r_cnt;
  end
`endif
endmodule
